// File: rtl/writeback_buffer.sv
// writeback_buffer: merges ALU and load results into a single register-file
// write port, queueing the losers of each cycle in a small in-order FIFO.
// R15 is written only through a separate pc path (RegWrite2/BusW2).
// Optional build macro WB_BYPASS_EN adds a combinational forwarding lookup
// (byp_rs/byp_hit/byp_data) over pending FIFO entries and the output register.
module writeback_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [3:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        pc_valid,
  input  logic [31:0] pc_data,
`ifdef WB_BYPASS_EN
  input  logic [3:0]  byp_rs,
  output logic        byp_hit,
  output logic [31:0] byp_data,
`endif
  output logic        RegWrite,
  output logic [3:0]  Rd,
  output logic [31:0] BusW,
  output logic        RegWrite2,
  output logic [31:0] BusW2,
  output logic        stall,
  output logic        overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_C = CW'(DEPTH - 1);

  logic [3:0]    rd_mem_r   [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic          mem_ok_s;
  logic          alu_ok_s;
  logic          head_ok_s;
  logic          issue_s;
  logic [3:0]    issue_rd_s;
  logic [31:0]   issue_data_s;
  logic          deq_s;
  logic          mem_enq_s;
  logic          alu_enq_s;
  logic          mem_acc_s;
  logic          alu_acc_s;
  logic          drop_s;
  logic [CW-1:0] cnt_deq_s;
  logic [CW-1:0] cnt_mid_s;
  logic [CW-1:0] count_nxt_s;
  logic [PW-1:0] alu_slot_s;

  // Pick the oldest candidate to issue and decide which leftovers enqueue.
  // The head is freed before enqueues are sized, so a full FIFO with both
  // requests valid only loses the ALU (youngest) request.
  always_comb begin
    mem_ok_s     = mem_valid && (mem_rd != 4'd15);
    alu_ok_s     = alu_valid && (alu_rd != 4'd15);
    head_ok_s    = (count_r != {CW{1'b0}});
    issue_s      = 1'b0;
    issue_rd_s   = 4'd0;
    issue_data_s = 32'd0;
    if (head_ok_s) begin
      issue_s      = 1'b1;
      issue_rd_s   = rd_mem_r[head_r];
      issue_data_s = data_mem_r[head_r];
    end else if (mem_ok_s) begin
      issue_s      = 1'b1;
      issue_rd_s   = mem_rd;
      issue_data_s = mem_data;
    end else if (alu_ok_s) begin
      issue_s      = 1'b1;
      issue_rd_s   = alu_rd;
      issue_data_s = alu_data;
    end else begin
      issue_s      = 1'b0;
    end
    deq_s       = head_ok_s;
    mem_enq_s   = mem_ok_s && head_ok_s;
    alu_enq_s   = alu_ok_s && (head_ok_s || mem_ok_s);
    cnt_deq_s   = count_r - CW'(deq_s);
    mem_acc_s   = mem_enq_s && (cnt_deq_s < DEPTH_C);
    cnt_mid_s   = cnt_deq_s + CW'(mem_acc_s);
    alu_acc_s   = alu_enq_s && (cnt_mid_s < DEPTH_C);
    count_nxt_s = cnt_mid_s + CW'(alu_acc_s);
    drop_s      = (mem_enq_s && !mem_acc_s) || (alu_enq_s && !alu_acc_s);
    alu_slot_s  = tail_r + PW'(mem_acc_s);
  end

  // FIFO pointers and occupancy; reset discards any pending entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
    end else begin
      count_r <= count_nxt_s;
      head_r  <= head_r + PW'(deq_s);
      tail_r  <= tail_r + PW'(mem_acc_s) + PW'(alu_acc_s);
    end
  end

  // FIFO storage writes, mem request ahead of the ALU request.
  always_ff @(posedge clk) begin
    if (!reset && mem_acc_s) begin
      rd_mem_r[tail_r]   <= mem_rd;
      data_mem_r[tail_r] <= mem_data;
    end
    if (!reset && alu_acc_s) begin
      rd_mem_r[alu_slot_s]   <= alu_rd;
      data_mem_r[alu_slot_s] <= alu_data;
    end
  end

  // Port-1 output register; Rd/BusW hold when nothing issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite <= 1'b0;
      Rd       <= 4'd0;
      BusW     <= 32'd0;
    end else begin
      RegWrite <= issue_s;
      if (issue_s) begin
        Rd   <= issue_rd_s;
        BusW <= issue_data_s;
      end
    end
  end

  // R15 port, a one-cycle delayed copy of the pc request.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite2 <= 1'b0;
      BusW2     <= 32'd0;
    end else begin
      RegWrite2 <= pc_valid;
      if (pc_valid) begin
        BusW2 <= pc_data;
      end
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop_s) begin
      overflow <= 1'b1;
    end
  end

  // Hold upstream while fewer than two free slots remain.
  always_comb begin
    stall = (count_r >= STALL_C);
  end

`ifdef WB_BYPASS_EN
  logic [PW-1:0] byp_idx_s;

  // Forwarding lookup: output register first, then FIFO oldest to youngest,
  // so the last match seen is the youngest value.
  always_comb begin
    byp_hit   = 1'b0;
    byp_data  = 32'd0;
    byp_idx_s = head_r;
    if (RegWrite && (Rd == byp_rs)) begin
      byp_hit  = 1'b1;
      byp_data = BusW;
    end else begin
      byp_hit  = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      byp_idx_s = head_r + PW'(i);
      if ((CW'(i) < count_r) && (rd_mem_r[byp_idx_s] == byp_rs)) begin
        byp_hit  = 1'b1;
        byp_data = data_mem_r[byp_idx_s];
      end else begin
        byp_hit  = byp_hit;
      end
    end
  end
`endif

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, pending-write FIFO entries (power of 2, >=4).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports alu_valid/alu_rd/alu_data  in  1/4/32  ALU result write request.
REQ-005 SHALL have ports mem_valid/mem_rd/mem_data  in  1/4/32  load result write request, older than same-cycle ALU request.
REQ-006 SHALL have ports pc_valid/pc_data  in  1/32  R15 update request.
REQ-007 SHALL have ports RegWrite/Rd/BusW  out  1/4/32  register-file port-1 write, registered.
REQ-008 SHALL have ports RegWrite2/BusW2  out  1/32  register-file R15 write, registered.
REQ-009 SHALL have port stall  out  1  upstream must hold; combinational from occupancy.
REQ-010 SHALL have port overflow  out  1  sticky error flag, registered.

Function
REQ-011 Each cycle SHALL issue at most one port-1 write; candidate order: FIFO head, then mem request, then ALU request.
REQ-012 Non-issued valid requests SHALL enqueue same cycle, mem before ALU; FIFO thus preserves program order.
REQ-013 Issued request at edge N SHALL appear on RegWrite/Rd/BusW after edge N (latency 1); register file commits at edge N+1.
REQ-014 RegWrite SHALL be 0 in any cycle with no candidate; Rd/BusW SHALL hold previous values.
REQ-015 alu/mem requests with rd=15 SHALL be discarded (neither issued nor enqueued); R15 written only via pc path.
REQ-016 pc_valid at edge N SHALL produce RegWrite2=1, BusW2=pc_data after edge N, 1 cycle; independent of FIFO and stall.
REQ-017 Occupancy count SHALL range 0..DEPTH; simultaneous dequeue+enqueue SHALL net correctly; pointers wrap modulo DEPTH.
REQ-018 stall SHALL be 1 when count >= DEPTH-1 (guarantees room for worst-case two enqueues).
REQ-019 Enqueue attempt with count==DEPTH SHALL drop that request and set overflow=1 until reset.
REQ-020 Two same-cycle requests to the same rd SHALL both commit, mem first, so ALU value is final.

Reset
REQ-021 reset=1 at a posedge SHALL clear count, pointers, RegWrite, RegWrite2, overflow; Rd=0, BusW=0, BusW2=0.
REQ-022 reset SHALL take priority over all same-cycle requests; pending FIFO entries SHALL be discarded, never written.
REQ-023 stall SHALL be 0 in the cycle following reset.

Configuration
REQ-024 Macro WB_BYPASS_EN SHALL, when defined, add ports byp_rs in 4, byp_hit out 1, byp_data out 32 (combinational).
REQ-025 With WB_BYPASS_EN: byp_hit=1 when byp_rs matches any FIFO entry or registered Rd with RegWrite=1; byp_data = youngest match (FIFO tail-most first, then output register).
REQ-026 Without WB_BYPASS_EN: ports absent, no lookup logic; all other behaviour identical.

Verification
REQ-027 Single ALU request rd=3, data=0x0000_00AA, empty FIFO -> next cycle RegWrite=1, Rd=3, BusW=0xAA; count stays 0.
REQ-028 Same cycle mem rd=5 data=0x11, ALU rd=5 data=0x22 -> cycle1 BusW=0x11, cycle2 BusW=0x22, RegWrite=1 both cycles.
REQ-029 DEPTH=4, dual requests every cycle -> stall rises when count reaches 3; forced extra requests at count=4 -> overflow=1, held after requests stop.
REQ-030 ALU rd=15 data=0x99 with pc_valid data=0x40 -> RegWrite=0, RegWrite2=1, BusW2=0x40; 0x99 never appears on BusW.
REQ-031 Reset asserted with count=2 and mem request valid -> next cycle RegWrite=0, count=0, stall=0, overflow=0; no queued data emerges afterward.
REQ-032 WB_BYPASS_EN defined, FIFO holds rd=7 0x10 then rd=7 0x20 -> byp_rs=7 gives byp_hit=1, byp_data=0x20; byp_rs=8 gives byp_hit=0.
